// File: rtl/mtrx_slice_wconv_fifo.sv
// Width-down-converting synchronous FIFO: stores WR_W-bit rows, returns RD_W-bit
// slices in LSB- or MSB-first order, with registered fill count and status flags.
module mtrx_slice_wconv_fifo #(
    parameter int WR_W      = 64,
    parameter int RD_W      = 8,
    parameter int RATIO     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_WORDS  = 2,
    parameter int LSB_FIRST = 1
) (
    input  logic                                clk,
    input  logic                                srst,
    input  logic [WR_W-1:0]                     din,
    input  logic                                wr_en,
    input  logic                                rd_en,
    output logic [RD_W-1:0]                     dout,
    output logic                                dout_vld,
    output logic                                full,
    output logic                                almost_full,
    output logic                                empty,
    output logic [$clog2(DEPTH*RATIO):0]        rd_count,
    output logic                                overflow,
    output logic                                underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(RATIO);
    localparam int PW = AW + SW + 1;
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [WR_W-1:0] mem [DEPTH];

    logic [AW:0]   wr_ptr;
    logic [AW:0]   wr_ptr_n;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_n;
    logic [AW:0]   used_n;
    logic [AW:0]   free_n;
    logic [PW-1:0] count_n;
    logic          wr_ok;
    logic          rd_ok;
    logic [SW-1:0] slice_k;
    logic [SW-1:0] slice_sel;
    logic [WR_W-1:0] rd_word;
    logic [RD_W-1:0] slice_n;

    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    // Next-state pointers drive the registered flags so they always describe
    // the FIFO contents after this edge's accepted operations.
    always_comb begin
        wr_ptr_n = wr_ptr + (AW+1)'(wr_ok);
        rd_ptr_n = rd_ptr + PW'(rd_ok);
        used_n   = wr_ptr_n - rd_ptr_n[PW-1:SW];
        free_n   = DEPTH_V - used_n;
        count_n  = {wr_ptr_n, {SW{1'b0}}} - rd_ptr_n;
    end

    // Reversing the slice index (~k == RATIO-1-k for power-of-two RATIO) gives MSB-first order.
    always_comb begin
        slice_k   = rd_ptr[SW-1:0];
        slice_sel = (LSB_FIRST != 0) ? slice_k : ~slice_k;
        rd_word   = mem[rd_ptr[PW-2:SW]];
        slice_n   = rd_word[int'(slice_sel)*RD_W +: RD_W];
    end

    always_ff @(posedge clk) begin
        if (!srst && wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            dout        <= '0;
            dout_vld    <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            full        <= 1'b0;
            almost_full <= (DEPTH <= AF_WORDS);
            empty       <= 1'b1;
            rd_count    <= '0;
        end else begin
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            dout_vld    <= rd_ok;
            if (rd_ok) begin
                dout <= slice_n;
            end
            overflow    <= wr_en & full;
            underflow   <= rd_en & empty;
            full        <= (used_n == DEPTH_V);
            almost_full <= (32'(free_n) <= 32'(AF_WORDS));
            empty       <= (count_n == '0);
            rd_count    <= count_n;
        end
    end

endmodule

// File: tb/tb_mtrx_slice_wconv_fifo.sv
// Scoreboard bench: drives LSB-first and MSB-first instances with identical
// stimulus; a word-level model predicts slices and flags.
module tb_mtrx_slice_wconv_fifo;

    logic        clk;
    logic        srst;
    logic [63:0] din;
    logic        wr_en;
    logic        rd_en;

    logic [7:0]  a_dout, b_dout;
    logic        a_vld, b_vld, a_full, b_full, a_af, b_af, a_empty, b_empty;
    logic        a_ovf, b_ovf, a_unf, b_unf;
    logic [7:0]  a_count, b_count;

    mtrx_slice_wconv_fifo #(.LSB_FIRST(1)) dut_a (
        .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(a_dout), .dout_vld(a_vld), .full(a_full), .almost_full(a_af),
        .empty(a_empty), .rd_count(a_count), .overflow(a_ovf), .underflow(a_unf)
    );

    mtrx_slice_wconv_fifo #(.LSB_FIRST(0)) dut_b (
        .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(b_dout), .dout_vld(b_vld), .full(b_full), .almost_full(b_af),
        .empty(b_empty), .rd_count(b_count), .overflow(b_ovf), .underflow(b_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [63:0] words[$];
    int          rd_idx = 0;
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    logic        m_vld, m_full, m_af, m_empty, m_ovf, m_unf;
    int          m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output();
        chk("a_vld",   32'(a_vld),   32'(m_vld));
        chk("a_full",  32'(a_full),  32'(m_full));
        chk("a_af",    32'(a_af),    32'(m_af));
        chk("a_empty", 32'(a_empty), 32'(m_empty));
        chk("a_count", 32'(a_count), 32'(m_count));
        chk("a_ovf",   32'(a_ovf),   32'(m_ovf));
        chk("a_unf",   32'(a_unf),   32'(m_unf));
        chk("b_vld",   32'(b_vld),   32'(m_vld));
        chk("b_empty", 32'(b_empty), 32'(m_empty));
        chk("b_count", 32'(b_count), 32'(m_count));
    endtask

    // Inputs change on the falling edge; the model predicts the state after the next rising edge.
    task automatic apply_stimulus(input logic w, input logic r, input logic [63:0] d, input logic rst);
        int  nsl;
        logic wr_ok, rd_ok;
        logic [63:0] cur;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        din   = d;
        srst  = rst;
        if (rst) begin
            words.delete();
            rd_idx  = 0;
            m_vld   = 1'b0;
            m_full  = 1'b0;
            m_af    = 1'b0;
            m_empty = 1'b1;
            m_count = 0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            nsl   = words.size() * 8 - rd_idx;
            wr_ok = w && (words.size() < 16);
            rd_ok = r && (nsl > 0);
            if (rd_ok) begin
                cur = words[0];
                exp_a.push_back(cur[rd_idx*8 +: 8]);
                exp_b.push_back(cur[(7-rd_idx)*8 +: 8]);
                rd_idx++;
                if (rd_idx == 8) begin
                    void'(words.pop_front());
                    rd_idx = 0;
                end
            end
            if (wr_ok) words.push_back(d);
            m_vld   = rd_ok;
            m_ovf   = w && !wr_ok;
            m_unf   = r && !rd_ok;
            m_count = words.size() * 8 - rd_idx;
            m_empty = (m_count == 0);
            m_full  = (words.size() == 16);
            m_af    = ((16 - words.size()) <= 2);
        end
        @(posedge clk);
        #1;
        check_output();
    endtask

    // Monitor: pops expected slices whenever dout_vld is seen, otherwise dout must hold.
    initial begin
        logic s_rst;
        logic [7:0] last_a, last_b, e;
        last_a = 8'h00;
        last_b = 8'h00;
        forever begin
            @(posedge clk);
            s_rst = srst;
            #1;
            if (s_rst) begin
                last_a = 8'h00;
                last_b = 8'h00;
                chk("a_dout_rst", 32'(a_dout), 32'h0);
                chk("b_dout_rst", 32'(b_dout), 32'h0);
            end else begin
                if (a_vld) begin
                    if (exp_a.size() == 0) chk("a_unexpected_vld", 32'(a_vld), 32'h0);
                    else begin
                        e = exp_a.pop_front();
                        chk("a_dout", 32'(a_dout), 32'(e));
                        last_a = e;
                    end
                end else chk("a_dout_hold", 32'(a_dout), 32'(last_a));
                if (b_vld) begin
                    if (exp_b.size() == 0) chk("b_unexpected_vld", 32'(b_vld), 32'h0);
                    else begin
                        e = exp_b.pop_front();
                        chk("b_dout", 32'(b_dout), 32'(e));
                        last_b = e;
                    end
                end else chk("b_dout_hold", 32'(b_dout), 32'(last_b));
            end
        end
    end

    initial begin
        srst  = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;

        $display("[TB] reset");
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);
        chk("rst_empty", 32'(a_empty), 32'h1);
        chk("rst_count", 32'(a_count), 32'h0);

        $display("[TB] write 10 words, read 8 slices");
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0, 64'h0000_0000_1234_5678, 1'b0);
        chk("count_after_10w", 32'(a_count), 32'd80);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b1, 64'h0, 1'b0);
        chk("count_after_8r", 32'(a_count), 32'd72);

        $display("[TB] drain and underflow");
        for (int i = 0; i < 16; i++) apply_stimulus(1'b0, 1'b1, 64'h0, 1'b0);
        for (int i = 0; i < 60; i++) apply_stimulus(1'b0, 1'b1, 64'h0, 1'b0);
        chk("drained_empty", 32'(a_empty), 32'h1);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b1, 64'h0, 1'b0);
            chk("extra_rd_unf", 32'(a_unf), 32'h1);
        end

        $display("[TB] fill to full and overflow");
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(1'b1, 1'b0, {8'hA0 + 8'(i), 48'h1122_3344_5566, 8'(i)}, 1'b0);
            if (i == 12) chk("af_before_14", 32'(a_af), 32'h0);
            if (i == 13) chk("af_after_14", 32'(a_af), 32'h1);
            if (i == 14) chk("full_before_16", 32'(a_full), 32'h0);
            if (i == 15) chk("full_after_16", 32'(a_full), 32'h1);
            if (i == 16) chk("ovf_17th", 32'(a_ovf), 32'h1);
        end
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b1, 64'h0, 1'b0);
            if (i == 6) chk("full_before_last_slice", 32'(a_full), 32'h1);
            if (i == 7) chk("full_after_last_slice", 32'(a_full), 32'h0);
        end
        apply_stimulus(1'b1, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        chk("refill_full", 32'(a_full), 32'h1);
        chk("refill_ovf", 32'(a_ovf), 32'h0);

        $display("[TB] MSB-first ordering");
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 64'h0102_0304_0506_0708, 1'b0);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b1, 64'h0, 1'b0);
            chk("b_msb_first", 32'(b_dout), 32'(i + 1));
        end

        $display("[TB] random concurrent traffic with mid-burst reset");
        for (int i = 0; i < 200; i++) begin
            if (i == 100) begin
                apply_stimulus(1'b1, 1'b1, {$urandom, $urandom}, 1'b1);
                chk("midrst_empty", 32'(a_empty), 32'h1);
                chk("midrst_count", 32'(a_count), 32'h0);
            end else begin
                apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               {$urandom, $urandom}, 1'b0);
            end
        end
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 64'h0, 1'b0);
        chk("exp_a_drained", 32'(exp_a.size()), 32'h0);
        chk("exp_b_drained", 32'(exp_b.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
